// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, active-area flags, line/frame/prefetch
// strobes and a sticky vblank interrupt, advanced by a divided pixel tick.
module video_timing_gen #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int H_BLANK  = 80,
    parameter int V_BLANK  = 80,
    parameter int PIX_DIV  = 1,
    parameter int PREFETCH = 8,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             irq_ack,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             de,
    output logic             vblank,
    output logic             line_start,
    output logic             frame_start,
    output logic             prefetch,
    output logic             vblank_irq,
    output logic [15:0]      frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_M1 = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_PF     = CNT_W'(H_TOTAL - PREFETCH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             h_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             next_line_active;

    always_comb begin
        tick   = en && (div == DIV_LAST);
        h_wrap = (hcnt == H_LAST);
        h_nxt  = h_wrap ? '0 : hcnt + CNT_W'(1);
        v_nxt  = vcnt;
        if (h_wrap) begin
            v_nxt = (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
        end
        // Prefetch never lands on a wrap tick, so vcnt is still the line being drawn.
        next_line_active = (vcnt < V_ACT_M1) || (vcnt == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            hcnt        <= H_LAST;
            vcnt        <= V_LAST;
            de          <= 1'b0;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            prefetch    <= 1'b0;
            vblank_irq  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            prefetch    <= 1'b0;
            if (en) begin
                div <= tick ? '0 : div + DIV_W'(1);
            end
            if (irq_ack) begin
                vblank_irq <= 1'b0;
            end
            if (tick) begin
                hcnt        <= h_nxt;
                vcnt        <= v_nxt;
                de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
                vblank      <= (v_nxt >= V_ACT);
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
                prefetch    <= (h_nxt == H_PF) && next_line_active;
                // Placed after the ack clear so a coincident set wins.
                if ((h_nxt == '0) && (v_nxt == V_ACT)) begin
                    vblank_irq <= 1'b1;
                end
                if ((h_nxt == '0) && (v_nxt == '0)) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule
